mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two requesters: the core's instruction-fetch port (IF) and its load/store port (D).
- Sits between riscv_core and a unified memory, replacing the separate instruction_memory and data_memory instances.
- Fixed priority: D over IF, with a starvation guard on IF.
- One-cycle memory read latency; the arbiter returns each read to the requester that issued it.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Owner encoding tags which requester the in-flight memory read belongs to.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MAX_D_STREAK = 4;
    localparam int STREAK_W         = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Writes complete at the grant edge, so only reads claim the response slot.
    function automatic owner_e next_owner(input logic if_gnt,
                                          input logic d_gnt,
                                          input logic d_we);
        owner_e own;
        own = OWN_NONE;
        if (if_gnt) begin
            own = OWN_IF;
        end else if (d_gnt && !d_we) begin
            own = OWN_D;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data port wins conflicts until it has
// won MAX_D_STREAK times in a row against a waiting fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                arb_en,
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] d_streak,
    output logic                if_gnt,
    output logic                d_gnt
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic starve;

    always_comb begin
        starve = (d_streak == STREAK_MAX);
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (arb_en) begin
            if (if_req && d_req) begin
                if_gnt = starve;
                d_gnt  = !starve;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch (IF) and
// load/store (D) ports, routing each one-cycle-latency read back to its issuer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] d_streak;
    owner_e              rsp_owner;

    // Byte-lane bits never reach the word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    mem_arb_pick #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_pick (
        .arb_en  (!rst),
        .if_req  (if_req),
        .d_req   (d_req),
        .d_streak(d_streak),
        .if_gnt  (if_gnt),
        .d_gnt   (d_gnt)
    );

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = if_addr[ADDR_W-1:2];
        mem_wdata = '0;
        mem_be    = if_gnt ? '1 : '0;
        if (d_gnt) begin
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_streak  <= '0;
            rsp_owner <= OWN_NONE;
        end else begin
            if (if_gnt || !if_req) begin
                d_streak <= '0;
            end else if (d_gnt && d_streak != STREAK_MAX) begin
                d_streak <= d_streak + 1'b1;
            end
            rsp_owner <= next_owner(if_gnt, d_gnt, d_we);
        end
    end

    // Gating with rst drops a read still in flight when reset arrives.
    assign if_rvalid = !rst && (rsp_owner == OWN_IF);
    assign d_rvalid  = !rst && (rsp_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-level
// reference model of the arbitration rules and a unified memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_D    = 4;
    localparam int BE_W     = DATA_W / 8;
    localparam int MEM_WORDS = 256;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_D_STREAK(MAX_D)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified memory the DUT talks to
    logic [DATA_W-1:0] mem_model [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_be[b]) mem_model[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem_model[mem_addr[7:0]];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    logic [DATA_W-1:0] exp_q[$];
    int pend_own;   // 0 none, 1 fetch, 2 data
    int streak;
    bit last_if_g, last_d_g;
    int n_cmp, n_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of DUT outputs to the model, then advance the model.
    task automatic check_cycle();
        logic [DATA_W-1:0] data;
        bit eif, ed;
        int widx;
        data = '0;
        if (pend_own != 0) data = exp_q.pop_front();
        chk("if_rvalid", {63'b0, if_rvalid}, {63'b0, (!rst && pend_own == 1)});
        chk("d_rvalid", {63'b0, d_rvalid}, {63'b0, (!rst && pend_own == 2)});
        if (!rst && pend_own == 1) chk("if_rdata", 64'(if_rdata), 64'(data));
        if (!rst && pend_own == 2) chk("d_rdata", 64'(d_rdata), 64'(data));

        eif = 1'b0;
        ed  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (streak == MAX_D) eif = 1'b1;
                else ed = 1'b1;
            end else begin
                eif = if_req;
                ed  = d_req;
            end
        end
        chk("if_gnt", {63'b0, if_gnt}, {63'b0, eif});
        chk("d_gnt", {63'b0, d_gnt}, {63'b0, ed});
        chk("mem_en", {63'b0, mem_en}, {63'b0, (eif | ed)});
        chk("mem_we", {63'b0, mem_we}, {63'b0, (ed & d_we)});
        if (eif) begin
            chk("mem_addr_if", 64'(mem_addr), 64'(if_addr / 4));
            chk("mem_be_if", 64'(mem_be), 64'hF);
        end
        if (ed) begin
            chk("mem_addr_d", 64'(mem_addr), 64'(d_addr / 4));
            if (d_we) begin
                chk("mem_be_d", 64'(mem_be), 64'(d_be));
                chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
            end
        end

        pend_own = 0;
        if (eif) begin
            pend_own = 1;
            exp_q.push_back(ref_mem[(if_addr / 4) % MEM_WORDS]);
        end else if (ed && !d_we) begin
            pend_own = 2;
            exp_q.push_back(ref_mem[(d_addr / 4) % MEM_WORDS]);
        end else if (ed && d_we) begin
            widx = int'((d_addr / 4) % MEM_WORDS);
            for (int b = 0; b < BE_W; b++)
                if (d_be[b]) ref_mem[widx][b*8 +: 8] = d_wdata[b*8 +: 8];
        end
        if (rst || eif || !if_req) streak = 0;
        else if (ed && streak < MAX_D) streak = streak + 1;
        last_if_g = eif;
        last_d_g  = ed;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic drive_if(input logic req, input logic [ADDR_W-1:0] addr);
        if_req  = req;
        if_addr = addr;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        d_req   = req;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_be    = be;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        n_cmp = 0;
        n_mis = 0;
        pend_own = 0;
        streak = 0;
        last_if_g = 1'b0;
        last_d_g = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            mem_model[i] = v;
            ref_mem[i] = v;
        end
        mem_model[4] = 32'h0050_0093;
        ref_mem[4]   = 32'h0050_0093;

        // Reset with both requests pending: nothing may be granted
        rst = 1'b1;
        drive_if(1'b1, 32'h10);
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        tick();
        tick();
        rst = 1'b0;
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Fetch only, three back-to-back grants of word 4
        drive_if(1'b1, 32'h0000_0010);
        repeat (3) tick();
        drive_if(1'b0, 32'h0);
        tick();

        // Data write then read back
        drive_d(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        tick();
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick();
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        chk("readback_const", 64'(ref_mem[64]), 64'hDEAD_BEEF);

        // Sustained conflict: D,D,D,D,IF repeating
        drive_if(1'b1, 32'h10);
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (10) tick();

        // Fetch drops after two D grants, then conflict restarts fresh
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive_if(1'b1, 32'h10);
        drive_d(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        repeat (2) tick();
        drive_if(1'b0, 32'h0);
        tick();
        drive_if(1'b1, 32'h14);
        repeat (5) tick();
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Reset hits while a data read is in flight
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick();
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        drive_if(1'b1, 32'h10);
        tick();
        rst = 1'b0;
        tick();
        drive_if(1'b0, 32'h0);
        tick();

        // Misaligned fetch lands on the same word
        drive_if(1'b1, 32'h0000_0013);
        #1;
        chk("misaligned_addr", 64'(mem_addr), 64'd4);
        tick();
        drive_if(1'b0, 32'h0);
        tick();

        // Randomized traffic with legal hold-until-grant requesters
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!if_req || last_if_g)
                drive_if($urandom_range(0, 3) != 0,
                         {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))});
            if (!d_req || last_d_g)
                drive_d($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
                        $urandom, 4'($urandom_range(1, 15)));
            tick();
        end
        rst = 1'b0;
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
